// File: rtl/device_table_reader_pkg.sv
// Shared types and constants for the device table lookup.
package device_table_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    DRAIN,
    DONE,
    ERR
  } state_e;

  // Issue order of the record words; also the capture steering tag.
  typedef enum logic [2:0] {
    TAG_IP_H,
    TAG_IP_L,
    TAG_TOFF_H,
    TAG_TOFF_L,
    TAG_DLEN,
    TAG_INTV
  } field_tag_e;

  localparam logic [3:0] OFF_IP_H   = 4'd0;
  localparam logic [3:0] OFF_IP_L   = 4'd1;
  localparam logic [3:0] OFF_TOFF_H = 4'd5;
  localparam logic [3:0] OFF_TOFF_L = 4'd6;
  localparam logic [3:0] OFF_DLEN   = 4'd7;
  localparam logic [3:0] OFF_INTV   = 4'd8;

  localparam int unsigned NUM_READS = 6;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_BAD_INDEX = 2'b01;
  localparam logic [1:0] ERR_NOT_CFG   = 2'b10;

  function automatic logic [3:0] tag_offset(input field_tag_e tag);
    case (tag)
      TAG_IP_H:   return OFF_IP_H;
      TAG_IP_L:   return OFF_IP_L;
      TAG_TOFF_H: return OFF_TOFF_H;
      TAG_TOFF_L: return OFF_TOFF_L;
      TAG_DLEN:   return OFF_DLEN;
      default:    return OFF_INTV;
    endcase
  endfunction

endpackage

// File: rtl/device_table_reader_rd_tag_pipe.sv
// Tag/valid delay line matching the RAM read latency.
module rd_tag_pipe
  import device_table_reader_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  field_tag_e i_tag,
  output logic       o_valid,
  output field_tag_e o_tag
);

  logic       valid_q [RD_LAT];
  field_tag_e tag_q   [RD_LAT];

  // shift tag and valid one stage per cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= TAG_IP_H;
      end
    end else begin
      valid_q[0] <= i_valid;
      tag_q[0]   <= i_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign o_valid = valid_q[RD_LAT-1];
  assign o_tag   = tag_q[RD_LAT-1];

endmodule

// File: rtl/device_table_reader.sv
// Reads one device record from table RAM and unpacks it into result fields.
module device_table_reader
  import device_table_reader_pkg::*;
#(
  parameter int unsigned ADDR_SZ   = 16,
  parameter int unsigned REC_WORDS = 9,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_DEV   = 254
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req,
  input  logic               i_cfg_valid,
  input  logic [7:0]         i_index,
  input  logic [ADDR_SZ-1:0] i_base_addr,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [1:0]         o_err_code,
  output logic [31:0]        o_ip,
  output logic [31:0]        o_toffset,
  output logic [15:0]        o_datalen,
  output logic [15:0]        o_interval,
  output logic [ADDR_SZ-1:0] o_ram_addr,
  output logic               o_ram_rd_en,
  input  logic [15:0]        i_ram_data
);

  if (REC_WORDS < 9) begin : g_rec_words_chk
    $error("device_table_reader: REC_WORDS must be at least 9");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_chk
    $error("device_table_reader: RD_LAT must be in 1..4");
  end

  state_e             state;
  logic [7:0]         idx_q;
  logic [ADDR_SZ-1:0] base_q;
  logic               cfg_q;
  logic [2:0]         cnt;
  logic [ADDR_SZ-1:0] addr_q;
  field_tag_e         tag_q;
  logic [ADDR_SZ-1:0] rec_base;
  logic               cap_valid;
  field_tag_e         cap_tag;

  // record base wraps modulo 2^ADDR_SZ
  assign rec_base = base_q + ADDR_SZ'(idx_q - 8'd1) * ADDR_SZ'(REC_WORDS);

  // idle address follows the live base input; reset forces it to zero
  assign o_ram_addr = i_rst ? '0 : (o_ram_rd_en ? addr_q : i_base_addr);

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (o_ram_rd_en),
    .i_tag   (tag_q),
    .o_valid (cap_valid),
    .o_tag   (cap_tag)
  );

  // lookup FSM with registered outputs and tag-steered field capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      cfg_q       <= 1'b0;
      cnt         <= '0;
      addr_q      <= '0;
      tag_q       <= TAG_IP_H;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_ip        <= '0;
      o_toffset   <= '0;
      o_datalen   <= '0;
      o_interval  <= '0;
      o_ram_rd_en <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_error <= 1'b0;

      if (cap_valid) begin
        case (cap_tag)
          TAG_IP_H:   o_ip[31:16]      <= i_ram_data;
          TAG_IP_L:   o_ip[15:0]       <= i_ram_data;
          TAG_TOFF_H: o_toffset[31:16] <= i_ram_data;
          TAG_TOFF_L: o_toffset[15:0]  <= i_ram_data;
          TAG_DLEN:   o_datalen        <= {1'b0, i_ram_data[15:1]};
          default:    o_interval       <= i_ram_data;
        endcase
      end

      case (state)
        IDLE: begin
          if (i_req) begin
            idx_q      <= i_index;
            base_q     <= i_base_addr;
            cfg_q      <= i_cfg_valid;
            o_err_code <= ERR_NONE;
            o_ip       <= '0;
            o_toffset  <= '0;
            o_datalen  <= '0;
            o_interval <= '0;
            o_busy     <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (!cfg_q) begin
            o_err_code <= ERR_NOT_CFG;
            state      <= ERR;
          end else if (idx_q == 8'd0 || 32'(idx_q) > MAX_DEV) begin
            o_err_code <= ERR_BAD_INDEX;
            state      <= ERR;
          end else begin
            o_ram_rd_en <= 1'b1;
            addr_q      <= rec_base + ADDR_SZ'(tag_offset(TAG_IP_H));
            tag_q       <= TAG_IP_H;
            cnt         <= 3'd1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt == 3'(NUM_READS)) begin
            o_ram_rd_en <= 1'b0;
            state       <= DRAIN;
          end else begin
            addr_q <= rec_base + ADDR_SZ'(tag_offset(field_tag_e'(cnt)));
            tag_q  <= field_tag_e'(cnt);
            cnt    <= cnt + 3'd1;
          end
        end
        DRAIN: begin
          if (cap_valid && cap_tag == TAG_INTV) begin
            state <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_error <= 1'b1;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_device_table_reader.sv
// Self-checking bench: three configurations run the same lookups side by side.
module tb_device_table_reader;

  localparam int NDUT = 3;
  localparam int AW  [NDUT] = '{16, 16, 8};
  localparam int LAT [NDUT] = '{1, 3, 2};
  localparam int MAXC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        cfg_valid;
  logic [7:0]  index;
  logic [15:0] base;
  logic [15:0] seed;

  logic        busy     [NDUT];
  logic        done     [NDUT];
  logic        error    [NDUT];
  logic        rd_en    [NDUT];
  logic [1:0]  err_code [NDUT];
  logic [31:0] ip       [NDUT];
  logic [31:0] toff     [NDUT];
  logic [15:0] dlen     [NDUT];
  logic [15:0] intv     [NDUT];
  logic [15:0] ram_addr [NDUT];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [15:0] a, input logic [15:0] s);
    return (a * 16'h9E37) ^ s ^ {a[7:0], a[15:8]};
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [AW[g]-1:0] addr_w;
    logic [15:0]      rdata;
    logic [15:0]      lat_q [LAT[g]];

    device_table_reader #(
      .ADDR_SZ   (AW[g]),
      .REC_WORDS (9),
      .RD_LAT    (LAT[g]),
      .MAX_DEV   (254)
    ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_cfg_valid (cfg_valid),
      .i_index     (index),
      .i_base_addr (base[AW[g]-1:0]),
      .o_busy      (busy[g]),
      .o_done      (done[g]),
      .o_error     (error[g]),
      .o_err_code  (err_code[g]),
      .o_ip        (ip[g]),
      .o_toffset   (toff[g]),
      .o_datalen   (dlen[g]),
      .o_interval  (intv[g]),
      .o_ram_addr  (addr_w),
      .o_ram_rd_en (rd_en[g]),
      .i_ram_data  (rdata)
    );

    assign ram_addr[g] = 16'(addr_w);

    // RAM model: data for an rd_en cycle appears LAT cycles later
    always @(posedge clk) begin
      for (int i = LAT[g] - 1; i > 0; i--) lat_q[i] <= lat_q[i-1];
      lat_q[0] <= rd_en[g] ? ram_word(16'(addr_w), seed) : 16'hDEAD;
    end
    assign rdata = lat_q[LAT[g]-1];
  end

  task automatic check_all_zero(input string name);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (busy[d] !== 1'b0 || done[d] !== 1'b0 || error[d] !== 1'b0 || rd_en[d] !== 1'b0 ||
          err_code[d] !== 2'b00 || ip[d] !== 32'h0 || toff[d] !== 32'h0 || dlen[d] !== 16'h0 ||
          intv[d] !== 16'h0 || ram_addr[d] !== 16'h0) begin
        errors++;
        $display("FAIL %s dut%0d: got busy=%b done=%b err=%b rd=%b code=%b ip=%h toff=%h dlen=%h intv=%h addr=%h expected all zero",
                 name, d, busy[d], done[d], error[d], rd_en[d], err_code[d], ip[d], toff[d], dlen[d], intv[d], ram_addr[d]);
      end
    end
  endtask

  // One lookup on all DUTs, observed in cycle n = after active edge n (edge 0 samples i_req).
  task automatic run_lookup(input logic c, input logic [7:0] idx, input logic [15:0] b,
                            input bit extra_req, input string name);
    int          off [6] = '{0, 1, 5, 6, 7, 8};
    int          exp_err;
    int          n_rd     [NDUT];
    int          done_cyc [NDUT];
    int          done_cnt [NDUT];
    int          err_cyc  [NDUT];
    int          err_cnt  [NDUT];
    int          rbi;
    logic [15:0] m, ea, w [6];
    bit          exp_busy;

    exp_err = !c ? 2 : ((idx == 8'd0 || idx > 8'd254) ? 1 : 0);
    rbi = int'(b) + (int'(idx) - 1) * 9;
    for (int d = 0; d < NDUT; d++) begin
      n_rd[d] = 0; done_cyc[d] = -1; done_cnt[d] = 0; err_cyc[d] = -1; err_cnt[d] = 0;
    end

    @(negedge clk);
    seed      = 16'($urandom);
    cfg_valid = c;
    index     = idx;
    base      = b;
    req       = 1'b1;
    @(negedge clk);
    req = 1'b0;

    for (int cyc = 0; cyc < MAXC; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (extra_req && exp_err == 0 && cyc == 3) begin
        req   = 1'b1;
        index = idx ^ 8'h5A;
      end else begin
        req = 1'b0;
      end
      for (int d = 0; d < NDUT; d++) begin
        m = 16'((32'd1 << AW[d]) - 1);
        if (cyc == 0) begin
          checks++;
          if (ip[d] !== 32'h0 || toff[d] !== 32'h0 || dlen[d] !== 16'h0 || intv[d] !== 16'h0 || err_code[d] !== 2'b00) begin
            errors++;
            $display("FAIL %s accept_clear dut%0d: got ip=%h toff=%h dlen=%h intv=%h code=%b expected zeros",
                     name, d, ip[d], toff[d], dlen[d], intv[d], err_code[d]);
          end
        end
        exp_busy = (exp_err != 0) ? (cyc < 2) : (cyc < 8 + LAT[d]);
        checks++;
        if (busy[d] !== exp_busy) begin
          errors++;
          $display("FAIL %s busy dut%0d cycle %0d: got %b expected %b", name, d, cyc, busy[d], exp_busy);
        end
        if (rd_en[d] === 1'b1) begin
          if (n_rd[d] < 6) begin
            ea = 16'(rbi + off[n_rd[d]]) & m;
            checks++;
            if (ram_addr[d] !== ea) begin
              errors++;
              $display("FAIL %s rd_addr%0d dut%0d: got %h expected %h", name, n_rd[d], d, ram_addr[d], ea);
            end
          end
          n_rd[d]++;
        end else begin
          checks++;
          if (ram_addr[d] !== (b & m)) begin
            errors++;
            $display("FAIL %s idle_addr dut%0d cycle %0d: got %h expected %h", name, d, cyc, ram_addr[d], b & m);
          end
        end
        if (done[d] === 1'b1) begin
          if (done_cyc[d] < 0) done_cyc[d] = cyc;
          done_cnt[d]++;
        end
        if (error[d] === 1'b1) begin
          if (err_cyc[d] < 0) err_cyc[d] = cyc;
          err_cnt[d]++;
          checks++;
          if (err_code[d] !== 2'(exp_err)) begin
            errors++;
            $display("FAIL %s err_code_at_pulse dut%0d: got %b expected %0d", name, d, err_code[d], exp_err);
          end
        end
      end
    end

    for (int d = 0; d < NDUT; d++) begin
      m = 16'((32'd1 << AW[d]) - 1);
      for (int k = 0; k < 6; k++) w[k] = ram_word(16'(rbi + off[k]) & m, seed);
      checks++;
      if (n_rd[d] != ((exp_err == 0) ? 6 : 0)) begin
        errors++;
        $display("FAIL %s rd_count dut%0d: got %0d expected %0d", name, d, n_rd[d], (exp_err == 0) ? 6 : 0);
      end
      checks++;
      if (exp_err == 0) begin
        if (done_cyc[d] != 8 + LAT[d] || done_cnt[d] != 1 || err_cnt[d] != 0) begin
          errors++;
          $display("FAIL %s done_timing dut%0d: got cycle %0d pulses %0d errors %0d expected cycle %0d pulses 1 errors 0",
                   name, d, done_cyc[d], done_cnt[d], err_cnt[d], 8 + LAT[d]);
        end
      end else begin
        if (err_cyc[d] != 2 || err_cnt[d] != 1 || done_cnt[d] != 0) begin
          errors++;
          $display("FAIL %s error_timing dut%0d: got cycle %0d pulses %0d dones %0d expected cycle 2 pulses 1 dones 0",
                   name, d, err_cyc[d], err_cnt[d], done_cnt[d]);
        end
      end
      checks++;
      if (err_code[d] !== 2'(exp_err)) begin
        errors++;
        $display("FAIL %s err_code dut%0d: got %b expected %0d", name, d, err_code[d], exp_err);
      end
      checks++;
      if (exp_err == 0) begin
        if (ip[d] !== {w[0], w[1]} || toff[d] !== {w[2], w[3]} || dlen[d] !== (w[4] >> 1) || intv[d] !== w[5]) begin
          errors++;
          $display("FAIL %s fields dut%0d: got ip=%h toff=%h dlen=%h intv=%h expected ip=%h toff=%h dlen=%h intv=%h",
                   name, d, ip[d], toff[d], dlen[d], intv[d], {w[0], w[1]}, {w[2], w[3]}, w[4] >> 1, w[5]);
        end
      end else begin
        if (ip[d] !== 32'h0 || toff[d] !== 32'h0 || dlen[d] !== 16'h0 || intv[d] !== 16'h0) begin
          errors++;
          $display("FAIL %s fields_cleared dut%0d: got ip=%h toff=%h dlen=%h intv=%h expected zeros",
                   name, d, ip[d], toff[d], dlen[d], intv[d]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; cfg_valid = 1'b1; index = 8'd7; base = 16'h1234; seed = 16'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_valid_lookup();
    run_lookup(1'b1, 8'd3, 16'h0100, 1'b0, "valid");
    run_lookup(1'b1, 8'd1, 16'h2000, 1'b0, "index_min");
    run_lookup(1'b1, 8'd254, 16'h0040, 1'b0, "index_max");
  endtask

  task automatic test_bad_index();
    run_lookup(1'b1, 8'd0, 16'h0100, 1'b0, "bad_index_zero");
    run_lookup(1'b1, 8'hFF, 16'h0100, 1'b0, "bad_index_ff");
  endtask

  task automatic test_not_configured();
    run_lookup(1'b1, 8'd5, 16'h0300, 1'b0, "cfg_prime");
    run_lookup(1'b0, 8'd5, 16'h0300, 1'b0, "not_configured");
    run_lookup(1'b0, 8'd0, 16'h0300, 1'b0, "cfg_priority");
  endtask

  task automatic test_wrap_busy();
    run_lookup(1'b1, 8'd4, 16'h00F0, 1'b1, "wrap_busy");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    seed = 16'($urandom); cfg_valid = 1'b1; index = 8'd9; base = 16'h0500; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (7) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (busy[d] !== 1'b1 || done[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_pre dut%0d: got busy=%b done=%b expected busy=1 done=0", d, busy[d], done[d]);
      end
    end
    #1 rst = 1'b1;
    #1 check_all_zero("reset_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        checks++;
        if (done[d] !== 1'b0 || error[d] !== 1'b0 || busy[d] !== 1'b0 || rd_en[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset_abort dut%0d cycle %0d: got done=%b err=%b busy=%b rd=%b expected all 0",
                   d, cyc, done[d], error[d], busy[d], rd_en[d]);
        end
      end
    end
    run_lookup(1'b1, 8'd9, 16'h0500, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int          r;
    logic [7:0]  idx;
    logic        c;
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0:       idx = 8'd0;
        1:       idx = 8'hFF;
        2:       idx = 8'd254;
        3:       idx = 8'd1;
        default: idx = 8'($urandom_range(1, 255));
      endcase
      c = ($urandom_range(0, 5) != 0);
      run_lookup(c, idx, 16'($urandom), bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_valid_lookup();
    test_bad_index();
    test_not_configured();
    test_wrap_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/device_table_reader.md
DEVICE_TABLE_READER -- requirements
Module: device_table_reader

Interface
REQ-001 Parameter ADDR_SZ, default 16, RAM word-address width.
REQ-002 Parameter REC_WORDS, default 9, words per device record.
REQ-003 Parameter RD_LAT, default 1, RAM read latency in cycles (legal range 1..4).
REQ-004 Parameter MAX_DEV, default 254, highest legal device index.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: i_clk in 1 is the clock; i_rst in 1 is the reset.
REQ-006 i_req in 1: one-cycle lookup request.
REQ-007 i_cfg_valid in 1: device table is configured.
REQ-008 i_index in 8: device index (MAC low byte).
REQ-009 i_base_addr in ADDR_SZ: table base address.
REQ-010 o_busy out 1: lookup in progress.
REQ-011 o_done out 1: one-cycle pulse, results valid.
REQ-012 o_error out 1: one-cycle pulse, lookup rejected.
REQ-013 o_err_code out 2: 01 = bad index, 10 = not configured, 00 = none.
REQ-014 Result outputs: o_ip out 32, o_toffset out 32, o_datalen out 16, o_interval out 16.
REQ-015 RAM port: o_ram_addr out ADDR_SZ, o_ram_rd_en out 1, i_ram_data in 16.

Function
REQ-016 The FSM SHALL use states IDLE, CHECK, ISSUE, DRAIN, DONE and ERR.
REQ-017 IDLE->CHECK on i_req; i_index, i_base_addr and i_cfg_valid are sampled at that edge; i_req while not IDLE is ignored.
REQ-018 CHECK SHALL go to ERR if the sampled cfg_valid is 0 (code 10) or index is 0 or index > MAX_DEV (code 01), and to ISSUE otherwise; code 10 takes priority.
REQ-019 Record base SHALL be base + (index-1)*REC_WORDS, computed modulo 2^ADDR_SZ (wrap, no error).
REQ-020 ISSUE SHALL assert o_ram_rd_en for exactly 6 consecutive cycles at record offsets 0,1,5,6,7,8: IP_H, IP_L, TOFF_H, TOFF_L, DLEN, INTV.
REQ-021 Read data SHALL be captured exactly RD_LAT cycles after its rd_en cycle, steered by a tag pipeline of depth RD_LAT.
REQ-022 Captured fields: o_ip={IP_H,IP_L}; o_toffset={TOFF_H,TOFF_L}; o_datalen={1'b0,DLEN[15:1]}; o_interval=INTV.
REQ-023 DRAIN SHALL wait until the last tag is captured, then go to DONE; DONE pulses o_done for 1 cycle and returns to IDLE.
REQ-024 ERR SHALL pulse o_error with o_err_code for 1 cycle, issue no RAM read, and return to IDLE.
REQ-025 Latency: with i_req at edge 0, o_done SHALL be high in cycle 8+RD_LAT and o_error in cycle 2.
REQ-026 o_busy SHALL be high in every state except IDLE.
REQ-027 On an accepted request the result outputs SHALL clear to 0; otherwise they hold until the next accept.
REQ-028 o_err_code SHALL hold its value until the next accept, then clear to 00.
REQ-029 o_ram_addr SHALL equal i_base_addr whenever o_ram_rd_en is low.
REQ-030 If REC_WORDS < 9, synthesis SHALL fail (elaboration-time check).

Reset
REQ-031 On i_rst, outputs SHALL reset asynchronously: all results 0, o_busy/o_done/o_error/o_ram_rd_en 0, o_err_code 00, o_ram_addr 0, FSM IDLE, tag pipeline empty.
REQ-032 Reset mid-lookup SHALL abort with no o_done/o_error pulse; the first i_req after release starts a fresh lookup.

Structure
REQ-033 The shared package SHALL hold the record offsets (0,1,5,6,7,8), field-tag enum, error-code constants and FSM state encoding.
REQ-034 The tag/valid delay line SHALL be the sub-module rd_tag_pipe (parameter RD_LAT).

Verification
REQ-035 Valid lookup: RD_LAT=1, base=0x100, index=3, RAM[0x112..0x11A] preloaded -> addresses 0x112,0x113,0x117,0x118,0x119,0x11A issued; o_done in cycle 9; o_datalen=DLEN>>1.
REQ-036 Bad index: index=0, then index=0xFF -> o_error in cycle 2, o_err_code=01, no rd_en.
REQ-037 Not configured: i_cfg_valid=0, index=5 -> o_err_code=10; o_ip retains the previous value cleared to 0 by accept.
REQ-038 RD_LAT=3: same as REQ-035 -> o_done in cycle 11; every field correct.
REQ-039 Wrap and busy: ADDR_SZ=8, base=0xF0, index=4 -> first address 0x0B; a second i_req during ISSUE is ignored.
REQ-040 Reset asserted during DRAIN -> no o_done, outputs 0; the next request completes normally.
